// File: rtl/axi_full_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : axi_full_slave_pkg                                               |
// | Purpose : Shared AXI burst-type / response encodings and FSM state types   |
// |           for the axi_full_slave_mem block.                                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package axi_full_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   // WRAP and the reserved encoding are not supported; they run as INCR but
   // are flagged so every response for the burst reports SLVERR.
   function automatic logic burst_is_err(input logic [1:0] burst);
      return (burst != BURST_FIXED) && (burst != BURST_INCR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_slave_ram                                                    |
// | Purpose : Word-organised storage, one write port with byte enables and     |
// |           one registered read port. Contents are never reset; only the     |
// |           read-data register is.                                           |
// | Ports   : clk_i/rst_i   clock, async active-high reset (read reg only)     |
// |           we_i/waddr_i/wdata_i/wstrb_i  byte-masked write                  |
// |           re_i/raddr_i/rdata_o          synchronous read, holds if !re_i   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_slave_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [DATA_W/8-1:0]   wstrb_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < LANES; b++) begin
            if (wstrb_i[b]) begin
               mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Read samples the array before this cycle's write lands, so a
   // same-cycle read of the word being written returns the old data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_full_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_full_slave_mem                                               |
// | Purpose : AXI4 burst slave backed by a 2^(ADDR_WIDTH-2) x 32 memory.       |
// |           Independent write (AW/W/B) and read (AR/R) state machines;       |
// |           FIXED holds the index, INCR/WRAP/reserved increment it and the   |
// |           last two answer SLVERR.                                          |
// | Ports   : ACLK, ARESET (async, active-high)                                |
// |           S_AXI_AW*, S_AXI_W*, S_AXI_B*  write address / data / response   |
// |           S_AXI_AR*, S_AXI_R*            read address / data               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module axi_full_slave_mem
   import axi_full_slave_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 10,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RLAST,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   // ---------------- write channel state ----------------
   w_state_e         w_state_q, w_state_d;
   logic [IDX_W-1:0] w_idx_q, w_idx_d;
   logic [7:0]       w_len_q, w_len_d;
   logic [7:0]       w_cnt_q, w_cnt_d;
   logic             w_fixed_q, w_fixed_d;
   logic             w_err_q, w_err_d;
   logic             awready_q, awready_d;
   logic             wready_q, wready_d;
   logic             bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             ram_we;

   // ---------------- read channel state ----------------
   r_state_e         r_state_q, r_state_d;
   logic [IDX_W-1:0] r_idx_q, r_idx_d;
   logic [7:0]       r_len_q, r_len_d;
   logic [7:0]       r_cnt_q, r_cnt_d;
   logic             r_fixed_q, r_fixed_d;
   logic             r_err_q, r_err_d;
   logic             arready_q, arready_d;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q, rlast_d;
   logic [1:0]       rresp_q, rresp_d;
   logic             ram_re;
   logic [IDX_W-1:0] ram_raddr;

   // Byte offset bits are deliberately ignored.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ---------------- write FSM ----------------
   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_fixed_d = w_fixed_q;
      w_err_d   = w_err_q;
      ram_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (awready_q && S_AXI_AWVALID) begin
               w_idx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
               w_len_d   = S_AXI_AWLEN;
               w_cnt_d   = 8'd0;
               w_fixed_d = (S_AXI_AWBURST == BURST_FIXED);
               w_err_d   = burst_is_err(S_AXI_AWBURST);
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wready_q && S_AXI_WVALID) begin
               ram_we = 1'b1;
               // WLAST must coincide exactly with the final counted beat;
               // the burst still ends on the count either way.
               if (S_AXI_WLAST != (w_cnt_q == w_len_q)) begin
                  w_err_d = 1'b1;
               end
               if (!w_fixed_q) begin
                  w_idx_d = w_idx_q + 1'b1;
               end
               w_cnt_d = w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && S_AXI_BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      // Handshake outputs are registered copies of the next state so they
      // stay low while ARESET is held and rise on the first edge after.
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
      bresp_d   = ((w_state_d == W_RESP) && w_err_d) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_fixed_q <= 1'b0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_fixed_q <= w_fixed_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // ---------------- read FSM ----------------
   // The RAM is read only when a new beat must be presented (AR accept or
   // R handshake on a non-final beat), so RDATA holds while stalled and the
   // next word is ready on the following cycle without a bubble.
   always_comb begin
      r_state_d = r_state_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_fixed_d = r_fixed_q;
      r_err_d   = r_err_q;
      ram_re    = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (arready_q && S_AXI_ARVALID) begin
               r_idx_d   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
               r_len_d   = S_AXI_ARLEN;
               r_cnt_d   = 8'd0;
               r_fixed_d = (S_AXI_ARBURST == BURST_FIXED);
               r_err_d   = burst_is_err(S_AXI_ARBURST);
               ram_re    = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && S_AXI_RREADY) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d = r_cnt_q + 8'd1;
                  if (!r_fixed_q) begin
                     r_idx_d = r_idx_q + 1'b1;
                  end
                  ram_re = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      ram_raddr = r_idx_d;
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
      rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == r_len_d);
      rresp_d   = ((r_state_d == R_DATA) && r_err_d) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_fixed_q <= 1'b0;
         r_err_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_fixed_q <= r_fixed_d;
         r_err_q   <= r_err_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
      end
   end

   // ---------------- storage ----------------
   axi_slave_ram #(
      .ADDR_W (IDX_W),
      .DATA_W (C_S_AXI_DATA_WIDTH)
   ) u_ram (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .we_i    (ram_we),
      .waddr_i (w_idx_q),
      .wdata_i (S_AXI_WDATA),
      .wstrb_i (S_AXI_WSTRB),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (S_AXI_RDATA)
   );

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_full_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_axi_full_slave_mem                                            |
// | Purpose : Self-checking bench for axi_full_slave_mem: a table of write /   |
// |           read-back bursts, hand sequences for reset and same-word         |
// |           concurrency, and random bursts against a word-array model.       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_axi_full_slave_mem;

   logic        clk = 1'b0;
   logic        ARESET;
   logic [9:0]  AWADDR;
   logic [7:0]  AWLEN;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [9:0]  ARADDR;
   logic [7:0]  ARLEN;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   always #5 clk = ~clk;

   axi_full_slave_mem #(
      .C_S_AXI_ADDR_WIDTH (10),
      .C_S_AXI_DATA_WIDTH (32)
   ) dut (
      .ACLK          (clk),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (AWADDR),
      .S_AXI_AWLEN   (AWLEN),
      .S_AXI_AWBURST (AWBURST),
      .S_AXI_AWVALID (AWVALID),
      .S_AXI_AWREADY (AWREADY),
      .S_AXI_WDATA   (WDATA),
      .S_AXI_WSTRB   (WSTRB),
      .S_AXI_WLAST   (WLAST),
      .S_AXI_WVALID  (WVALID),
      .S_AXI_WREADY  (WREADY),
      .S_AXI_BRESP   (BRESP),
      .S_AXI_BVALID  (BVALID),
      .S_AXI_BREADY  (BREADY),
      .S_AXI_ARADDR  (ARADDR),
      .S_AXI_ARLEN   (ARLEN),
      .S_AXI_ARBURST (ARBURST),
      .S_AXI_ARVALID (ARVALID),
      .S_AXI_ARREADY (ARREADY),
      .S_AXI_RDATA   (RDATA),
      .S_AXI_RRESP   (RRESP),
      .S_AXI_RLAST   (RLAST),
      .S_AXI_RVALID  (RVALID),
      .S_AXI_RREADY  (RREADY)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: 256 words, byte-lane writes, index wraps modulo 256.
   logic [31:0] model [256];
   logic [31:0] wdat [256];
   logic [3:0]  wstb [256];

   typedef struct {
      logic [9:0]  addr;
      int          len;
      logic [1:0]  burst;
      logic [3:0]  strb;
      int          wlast;      // -1: on final beat, -2: never, else that beat
      logic [31:0] dbase;      // beat i carries dbase*(i+1)
      logic [1:0]  exp_bresp;
      logic [31:0] exp_first;  // first word read back afterwards
   } wvec_t;

   wvec_t vecs [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic sel(input int w);
      case (w)
         0:       return AWREADY;
         1:       return WREADY;
         2:       return BVALID;
         3:       return ARREADY;
         default: return RVALID;
      endcase
   endfunction

   // Waits (bounded) until the chosen signal is high at a falling edge.
   task automatic wait_hi(input int w, input string nm);
      int n = 0;
      @(negedge clk);
      while (!sel(w) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!sel(w)) begin
         tests++;
         fails++;
         $display("FAIL timeout_%s: got 0 expected 1", nm);
      end
   endtask

   function automatic logic [7:0] beat_idx(input logic [9:0] addr, input logic [1:0] burst, input int i);
      logic [7:0] base;
      logic [7:0] off;
      base = addr[9:2];
      off  = i[7:0];
      return (burst == 2'b00) ? base : base + off;
   endfunction

   task automatic model_write(input logic [7:0] idx, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic do_write(input logic [9:0] addr, input int len, input logic [1:0] burst,
                           input int wlast_beat, output logic [1:0] bresp);
      @(posedge clk); #1;
      AWADDR = addr; AWLEN = len[7:0]; AWBURST = burst; AWVALID = 1'b1;
      wait_hi(0, "awready");
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == wlast_beat); WVALID = 1'b1;
         wait_hi(1, "wready");
         @(posedge clk); #1;
         model_write(beat_idx(addr, burst, i), wdat[i], wstb[i]);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      @(negedge clk);
      check("wready_after_burst", {31'd0, WREADY}, 32'd0);
      @(posedge clk); #1;
      BREADY = 1'b1;
      wait_hi(2, "bvalid");
      bresp = BRESP;
      @(posedge clk); #1;
      BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] addr, input int len, input logic [1:0] burst,
                          input bit toggle, output logic [31:0] first);
      int i = 0;
      int cyc = 0;
      logic [31:0] exp;
      first = '0;
      @(posedge clk); #1;
      ARADDR = addr; ARLEN = len[7:0]; ARBURST = burst; ARVALID = 1'b1;
      wait_hi(3, "arready");
      @(posedge clk); #1;
      ARVALID = 1'b0;
      RREADY  = toggle ? 1'b0 : 1'b1;
      while (i <= len && cyc < 1200) begin
         @(negedge clk);
         exp = model[beat_idx(addr, burst, i)];
         check($sformatf("rvalid a%03h b%0d", addr, i), {31'd0, RVALID}, 32'd1);
         check($sformatf("rdata a%03h b%0d", addr, i), RDATA, exp);
         check($sformatf("rlast a%03h b%0d", addr, i), {31'd0, RLAST}, {31'd0, (i == len)});
         check($sformatf("rresp a%03h b%0d", addr, i), {30'd0, RRESP}, burst[1] ? 32'd2 : 32'd0);
         if (i == 0) first = RDATA;
         if (RVALID && RREADY) i++;
         @(posedge clk); #1;
         cyc++;
         if (toggle) RREADY = ~RREADY;
      end
      RREADY = 1'b0;
      if (i <= len) begin
         tests++;
         fails++;
         $display("FAIL read_beats a%03h: got %0d expected %0d", addr, i, len + 1);
      end
      @(negedge clk);
      check("rvalid_after_burst", {31'd0, RVALID}, 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [1:0]  bresp;
      logic [31:0] first, oldw, neww;
      int          wl;

      ARESET = 1'b1;
      AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

      // ---------- reset state ----------
      #13;
      check("rst_awready", {31'd0, AWREADY}, 32'd0);
      check("rst_arready", {31'd0, ARREADY}, 32'd0);
      check("rst_wready",  {31'd0, WREADY},  32'd0);
      check("rst_bvalid",  {31'd0, BVALID},  32'd0);
      check("rst_rvalid",  {31'd0, RVALID},  32'd0);
      check("rst_rlast",   {31'd0, RLAST},   32'd0);
      check("rst_resp",    {28'd0, BRESP, RRESP}, 32'd0);
      check("rst_rdata",   RDATA, 32'd0);
      @(posedge clk); #1;
      ARESET = 1'b0;
      @(negedge clk);
      check("rel_awready_low", {31'd0, AWREADY}, 32'd0);
      @(negedge clk);
      check("rel_awready", {31'd0, AWREADY}, 32'd1);
      check("rel_arready", {31'd0, ARREADY}, 32'd1);

      // ---------- table: write, then read back ----------
      // Row 0 fills every word so later partial-strobe writes are defined.
      vecs[0] = '{10'h000, 255, 2'b01, 4'hF,    -1, 32'h0101_0101, 2'b00, 32'h0101_0101};
      vecs[1] = '{10'h010,   3, 2'b01, 4'hF,    -1, 32'h0000_0011, 2'b00, 32'h0000_0011};
      vecs[2] = '{10'h020,   0, 2'b01, 4'hF,    -1, 32'hAABB_CCDD, 2'b00, 32'hAABB_CCDD};
      vecs[3] = '{10'h020,   0, 2'b01, 4'b0101, -1, 32'h0000_0000, 2'b00, 32'hAA00_CC00};
      vecs[4] = '{10'h100,   1, 2'b10, 4'hF,    -1, 32'h1234_0001, 2'b10, 32'h1234_0001};
      vecs[5] = '{10'h200,   3, 2'b01, 4'hF,     1, 32'h0BAD_0001, 2'b10, 32'h0BAD_0001};
      vecs[6] = '{10'h080,   2, 2'b00, 4'hF,    -1, 32'h0000_0101, 2'b00, 32'h0000_0303};
      vecs[7] = '{10'h300,   0, 2'b01, 4'hF,    -2, 32'h7777_7777, 2'b10, 32'h7777_7777};
      vecs[8] = '{10'h3F8,   3, 2'b01, 4'b1001, -1, 32'hC0DE_0001, 2'b00, 32'hC0FF_FF01};
      vecs[9] = '{10'h044,   2, 2'b11, 4'hF,    -1, 32'h2222_0003, 2'b10, 32'h2222_0003};

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i <= vecs[k].len; i++) begin
            wdat[i] = vecs[k].dbase * (i + 1);
            wstb[i] = vecs[k].strb;
         end
         wl = (vecs[k].wlast == -1) ? vecs[k].len : vecs[k].wlast;
         do_write(vecs[k].addr, vecs[k].len, vecs[k].burst, wl, bresp);
         check($sformatf("vec%0d_bresp", k), {30'd0, bresp}, {30'd0, vecs[k].exp_bresp});
         do_read(vecs[k].addr, vecs[k].len, vecs[k].burst, k[0], first);
         check($sformatf("vec%0d_first", k), first, vecs[k].exp_first);
      end

      // ---------- long wrapping read with RREADY toggling ----------
      do_read(10'h3FC, 255, 2'b01, 1'b1, first);
      check("wrap_first", first, model[255]);

      // ---------- reset in the middle of a write burst ----------
      @(posedge clk); #1;
      AWADDR = 10'h040; AWLEN = 8'd7; AWBURST = 2'b01; AWVALID = 1'b1;
      wait_hi(0, "awready_mid");
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         WDATA = 32'hD00D_0000 + i; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
         wait_hi(1, "wready_mid");
         @(posedge clk); #1;
         model_write(8'd16 + i[7:0], 32'hD00D_0000 + i, 4'hF);
      end
      WVALID = 1'b0;
      ARESET = 1'b1;
      #2;
      check("mid_rst_wready", {31'd0, WREADY}, 32'd0);
      check("mid_rst_awready", {31'd0, AWREADY}, 32'd0);
      check("mid_rst_bvalid", {31'd0, BVALID}, 32'd0);
      @(posedge clk); #1;
      ARESET = 1'b0;
      @(negedge clk);
      check("mid_rel_awready_low", {31'd0, AWREADY}, 32'd0);
      @(negedge clk);
      check("mid_rel_awready", {31'd0, AWREADY}, 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mid_no_bvalid", {31'd0, BVALID}, 32'd0);
      end
      do_read(10'h040, 1, 2'b01, 1'b0, first);
      check("mid_mem_kept", first, 32'hD00D_0000);
      wdat[0] = 32'h1357_9BDF; wstb[0] = 4'hF;
      wdat[1] = 32'h2468_ACE0; wstb[1] = 4'hF;
      do_write(10'h040, 1, 2'b01, 1, bresp);
      check("mid_next_bresp", {30'd0, bresp}, 32'd0);

      // ---------- same-cycle write and read of one word ----------
      oldw = model[48];
      neww = ~oldw;
      @(posedge clk); #1;
      AWADDR = 10'h0C0; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b1;
      wait_hi(0, "awready_cc");
      @(posedge clk); #1;
      AWVALID = 1'b0;
      WDATA = neww; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
      ARADDR = 10'h0C0; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1;
      @(negedge clk);
      check("cc_wready", {31'd0, WREADY}, 32'd1);
      check("cc_arready", {31'd0, ARREADY}, 32'd1);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0; RREADY = 1'b1;
      @(negedge clk);
      check("cc_rvalid", {31'd0, RVALID}, 32'd1);
      check("cc_old_data", RDATA, oldw);
      check("cc_rlast", {31'd0, RLAST}, 32'd1);
      @(posedge clk); #1;
      RREADY = 1'b0;
      model[48] = neww;
      BREADY = 1'b1;
      wait_hi(2, "bvalid_cc");
      check("cc_bresp", {30'd0, BRESP}, 32'd0);
      @(posedge clk); #1;
      BREADY = 1'b0;
      do_read(10'h0C0, 0, 2'b01, 1'b0, first);
      check("cc_new_data", first, neww);

      // ---------- random bursts against the model ----------
      for (int k = 0; k < 12; k++) begin
         logic [9:0] a;
         logic [1:0] bt;
         int         ln;
         a  = 10'($urandom_range(0, 1023));
         ln = $urandom_range(0, 15);
         bt = 2'($urandom_range(0, 3));
         for (int i = 0; i <= ln; i++) begin
            wdat[i] = $urandom;
            wstb[i] = 4'($urandom_range(0, 15));
         end
         do_write(a, ln, bt, ln, bresp);
         check($sformatf("rnd%0d_bresp", k), {30'd0, bresp}, bt[1] ? 32'd2 : 32'd0);
         a  = 10'($urandom_range(0, 1023));
         ln = $urandom_range(0, 15);
         bt = 2'($urandom_range(0, 3));
         do_read(a, ln, bt, 1'($urandom_range(0, 1)), first);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_full_slave_mem.md
AXI_FULL_SLAVE_MEM -- requirements
Module: axi_full_slave_mem

Interface
REQ-001 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 10, meaning byte-address width; memory depth is 2^(C_S_AXI_ADDR_WIDTH-2) 32-bit words.
REQ-002 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning data width; only 32 is supported.
REQ-003 The block SHALL have port ACLK  in  1  the single clock, all logic rising-edge.
REQ-004 The block SHALL have port ARESET  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port S_AXI_AWADDR  in  ADDR_WIDTH  write burst start address.
REQ-006 The block SHALL have port S_AXI_AWLEN  in  8  write beats minus one.
REQ-007 The block SHALL have port S_AXI_AWBURST  in  2  write burst type.
REQ-008 The block SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-009 The block SHALL have port S_AXI_AWREADY  out  1  write address ready.
REQ-010 The block SHALL have port S_AXI_WDATA  in  32  write data.
REQ-011 The block SHALL have port S_AXI_WSTRB  in  4  byte-lane enables.
REQ-012 The block SHALL have port S_AXI_WLAST  in  1  final write beat marker.
REQ-013 The block SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-014 The block SHALL have port S_AXI_WREADY  out  1  write data ready.
REQ-015 The block SHALL have port S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR).
REQ-016 The block SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-017 The block SHALL have port S_AXI_BREADY  in  1  write response ready.
REQ-018 The block SHALL have port S_AXI_ARADDR  in  ADDR_WIDTH  read burst start address.
REQ-019 The block SHALL have port S_AXI_ARLEN  in  8  read beats minus one.
REQ-020 The block SHALL have port S_AXI_ARBURST  in  2  read burst type.
REQ-021 The block SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-022 The block SHALL have port S_AXI_ARREADY  out  1  read address ready.
REQ-023 The block SHALL have port S_AXI_RDATA  out  32  read data.
REQ-024 The block SHALL have port S_AXI_RRESP  out  2  read response.
REQ-025 The block SHALL have port S_AXI_RLAST  out  1  final read beat marker.
REQ-026 The block SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-027 The block SHALL have port S_AXI_RREADY  in  1  read data ready.

Function
REQ-028 Write FSM SHALL have states W_IDLE (AWREADY=1), W_DATA (WREADY=1), W_RESP (BVALID=1); AW handshake -> W_DATA, beat len+1 accepted -> W_RESP, B handshake -> W_IDLE.
REQ-029 Read FSM SHALL have states R_IDLE (ARREADY=1), R_DATA; AR handshake -> R_DATA with RVALID=1 and first word on next cycle; R handshake on RLAST -> R_IDLE; read and write FSMs SHALL run independently.
REQ-030 Word index SHALL be addr[ADDR_WIDTH-1:2]; addr[1:0] and index overflow ignored, index wraps modulo depth.
REQ-031 Burst 01 INCR SHALL increment index per beat; 00 FIXED SHALL hold index; 10/11 SHALL execute as INCR and return SLVERR on every beat/response.
REQ-032 Each accepted W beat SHALL write only byte lanes with WSTRB set, visible to reads from the next cycle.
REQ-033 R beats SHALL be back-to-back with RREADY held high (no bubbles); RDATA/RLAST SHALL hold stable while RVALID=1 and RREADY=0; RLAST=1 exactly on beat len.
REQ-034 WLAST asserted before beat len or absent on beat len SHALL set BRESP=SLVERR; termination SHALL still be by beat count.
REQ-035 Same-cycle write and read of one word SHALL present old data on the read beat.
REQ-036 AWLEN=0/ARLEN=0 SHALL produce single-beat transfers; AWLEN=255 SHALL complete 256 beats.

Reset
REQ-037 ARESET SHALL force both FSMs to idle, AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST=0, BRESP/RRESP=00, RDATA=0, abandoning any burst with no response; AWREADY/ARREADY SHALL rise the first cycle after release; memory contents SHALL NOT be reset.

Structure
REQ-038 Package axi_full_slave_pkg SHALL hold burst-type and response constants and the FSM state enums.
REQ-039 Storage SHALL be sub-module axi_slave_ram (one write port with byte enables, one synchronous read port).

Verification
REQ-040 AW 0x010 INCR len 3, WDATA 0x11..0x44, WSTRB F -> BRESP 00; AR 0x010 len 3 -> 0x11,0x22,0x33,0x44, RLAST on beat 4.
REQ-041 Write 0xAABBCCDD then WSTRB 0101 data 0x00000000 at 0x020 -> read 0xAA00CC00.
REQ-042 Read INCR len 255 from 0x3FC with RREADY toggling each cycle -> index wraps to 0, 256 beats, data stable while stalled.
REQ-043 AWBURST 10 len 1 -> BRESP 10; WLAST on beat 1 of len 3 -> BRESP 10, 4 beats accepted.
REQ-044 ARESET mid-write after beat 2 of len 7 -> no BVALID, AWREADY=1 one cycle after release, next burst OKAY.
REQ-045 Concurrent read and write bursts to same word -> read returns pre-write data, subsequent read returns new data.
